// File: rtl/item_money_unit.sv
// Credit and selection datapath for a vending controller: accepts coins, latches the
// chosen item, and settles or refunds when the main FSM issues commands.
module item_money_unit #(
  parameter logic [7:0] PRICE0 = 8'd15,
  parameter logic [7:0] PRICE1 = 8'd20,
  parameter logic [7:0] PRICE2 = 8'd25,
  parameter logic [7:0] PRICE3 = 8'd50
) (
  input  logic       in_clka,
  input  logic       in_restart,
  input  logic [1:0] in_cmd,
  input  logic [1:0] in_item,
  input  logic [1:0] in_coin,
  input  logic       in_coin_valid,
  output logic [7:0] out_credit,
  output logic [1:0] out_item,
  output logic       out_item_valid,
  output logic       out_dispense,
  output logic [7:0] out_change,
  output logic       out_change_valid,
  output logic       out_err,
  output logic       out_coin_reject
);

  typedef enum logic [1:0] {IDLE, COLLECT, SETTLE, REFUND} state_t;

  localparam logic [1:0] CMD_SITEM  = 2'b00;
  localparam logic [1:0] CMD_SMONEY = 2'b01;
  localparam logic [1:0] CMD_CLEAR  = 2'b10;
  localparam logic [1:0] CMD_START  = 2'b11;
  localparam logic [31:0] PRICES = {PRICE3, PRICE2, PRICE1, PRICE0};

  state_t     state_reg, state_next;
  logic [1:0] prev_cmd_reg;
  logic [7:0] credit_reg, credit_next;
  logic [1:0] item_reg, item_next;
  logic       item_valid_reg, item_valid_next;
  logic [7:0] change_reg, change_next;
  logic       dispense_reg, dispense_next;
  logic       change_valid_reg, change_valid_next;
  logic       err_reg, err_next;
  logic       coin_reject_reg, coin_reject_next;

  logic [7:0] price_tbl [4];
  logic [7:0] coin_value;
  logic [8:0] coin_sum;
  logic [7:0] price_sel;
  logic       cmd_entry;
  logic       clear_entry;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_price
      assign price_tbl[gi] = PRICES[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    coin_value = 8'd1;
    case (in_coin)
      2'b00:   coin_value = 8'd1;
      2'b01:   coin_value = 8'd5;
      2'b10:   coin_value = 8'd10;
      default: coin_value = 8'd25;
    endcase
  end

  assign coin_sum    = {1'b0, credit_reg} + {1'b0, coin_value};
  assign price_sel   = price_tbl[item_reg];
  assign cmd_entry   = (in_cmd != prev_cmd_reg);
  assign clear_entry = cmd_entry && (in_cmd == CMD_CLEAR);

  always_comb begin
    state_next        = state_reg;
    credit_next       = credit_reg;
    item_next         = item_reg;
    item_valid_next   = item_valid_reg;
    change_next       = change_reg;
    dispense_next     = 1'b0;
    change_valid_next = 1'b0;
    err_next          = 1'b0;
    coin_reject_next  = 1'b0;

    // Coins are only credited while collecting under START; a CLEAR entry
    // can never coincide with START, so it always rejects the coin.
    if (in_coin_valid) begin
      if (state_reg == COLLECT && in_cmd == CMD_START && !coin_sum[8])
        credit_next = coin_sum[7:0];
      else
        coin_reject_next = 1'b1;
    end

    if (clear_entry) begin
      state_next = REFUND;
    end else begin
      case (state_reg)
        IDLE, COLLECT: begin
          if (cmd_entry && in_cmd == CMD_SITEM) begin
            item_next       = in_item;
            item_valid_next = 1'b1;
          end
          if (state_reg == IDLE && cmd_entry && in_cmd == CMD_START)
            state_next = COLLECT;
          if (state_reg == COLLECT && cmd_entry && in_cmd == CMD_SMONEY)
            state_next = SETTLE;
        end
        SETTLE: begin
          state_next = IDLE;
          if (item_valid_reg && credit_reg >= price_sel) begin
            dispense_next     = 1'b1;
            change_next       = credit_reg - price_sel;
            change_valid_next = 1'b1;
            credit_next       = 8'd0;
            item_valid_next   = 1'b0;
          end else begin
            err_next = 1'b1;
          end
        end
        default: begin
          state_next      = IDLE;
          credit_next     = 8'd0;
          item_valid_next = 1'b0;
          if (credit_reg != 8'd0) begin
            change_next       = credit_reg;
            change_valid_next = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge in_clka) begin
    if (in_restart) begin
      state_reg        <= IDLE;
      prev_cmd_reg     <= CMD_CLEAR;
      credit_reg       <= 8'd0;
      item_reg         <= 2'd0;
      item_valid_reg   <= 1'b0;
      change_reg       <= 8'd0;
      dispense_reg     <= 1'b0;
      change_valid_reg <= 1'b0;
      err_reg          <= 1'b0;
      coin_reject_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      prev_cmd_reg     <= in_cmd;
      credit_reg       <= credit_next;
      item_reg         <= item_next;
      item_valid_reg   <= item_valid_next;
      change_reg       <= change_next;
      dispense_reg     <= dispense_next;
      change_valid_reg <= change_valid_next;
      err_reg          <= err_next;
      coin_reject_reg  <= coin_reject_next;
    end
  end

  assign out_credit       = credit_reg;
  assign out_item         = item_reg;
  assign out_item_valid   = item_valid_reg;
  assign out_dispense     = dispense_reg;
  assign out_change       = change_reg;
  assign out_change_valid = change_valid_reg;
  assign out_err          = err_reg;
  assign out_coin_reject  = coin_reject_reg;

endmodule

// File: tb/tb_item_money_unit.sv
// Scenario bench for item_money_unit: tasks push expected pulse events into a
// scoreboard queue that a negedge monitor drains, and check credit/selection inline.
module tb_item_money_unit;

  localparam logic [1:0] SITEM = 2'b00, SMONEY = 2'b01, CLEAR = 2'b10, START = 2'b11;
  localparam int K_DISP = 0, K_CHG = 1, K_ERR = 2, K_REJ = 3;

  typedef struct {
    int kind;
    int val;
  } exp_t;

  logic       in_clka = 1'b0;
  logic       in_restart;
  logic [1:0] in_cmd;
  logic [1:0] in_item;
  logic [1:0] in_coin;
  logic       in_coin_valid;
  logic [7:0] out_credit;
  logic [1:0] out_item;
  logic       out_item_valid;
  logic       out_dispense;
  logic [7:0] out_change;
  logic       out_change_valid;
  logic       out_err;
  logic       out_coin_reject;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  item_money_unit dut (
    .in_clka          (in_clka),
    .in_restart       (in_restart),
    .in_cmd           (in_cmd),
    .in_item          (in_item),
    .in_coin          (in_coin),
    .in_coin_valid    (in_coin_valid),
    .out_credit       (out_credit),
    .out_item         (out_item),
    .out_item_valid   (out_item_valid),
    .out_dispense     (out_dispense),
    .out_change       (out_change),
    .out_change_valid (out_change_valid),
    .out_err          (out_err),
    .out_coin_reject  (out_coin_reject)
  );

  always #5 in_clka = ~in_clka;

  // Scoreboard: every observed pulse must match the next expected event, in order.
  logic mon_p;
  int   mon_v;
  exp_t mon_e;
  always @(negedge in_clka) begin
    for (int k = 0; k < 4; k++) begin
      case (k)
        K_DISP:  begin mon_p = out_dispense;     mon_v = int'(out_item);   end
        K_CHG:   begin mon_p = out_change_valid; mon_v = int'(out_change); end
        K_ERR:   begin mon_p = out_err;          mon_v = 0;                end
        default: begin mon_p = out_coin_reject;  mon_v = 0;                end
      endcase
      if (mon_p === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_pulse got kind=%0d value=%0d, required no pulse", k, mon_v);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.kind != k || mon_e.val != mon_v) begin
            miscompares++;
            $display("FAIL scoreboard got kind=%0d value=%0d, required kind=%0d value=%0d",
                     k, mon_v, mon_e.kind, mon_e.val);
          end else begin
            $display("event kind=%0d value=%0d at %0t", k, mon_v, $time);
          end
        end
      end
    end
  end

  task automatic step(input logic [1:0] cmd, input logic cv, input logic [1:0] coin,
                      input logic [1:0] item, input logic rst);
    in_cmd = cmd; in_coin_valid = cv; in_coin = coin; in_item = item; in_restart = rst;
    @(posedge in_clka);
    #1;
  endtask

  task automatic test_reset();
    step(CLEAR, 0, 0, 0, 1);
    step(CLEAR, 0, 0, 0, 1);
    step(CLEAR, 0, 0, 0, 0);
    vectors++;
    if (out_credit !== 8'd0 || out_item !== 2'd0 || out_item_valid !== 1'b0 || out_change !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_state got credit=%0d item=%0d valid=%0b change=%0d, required all zero",
               out_credit, out_item, out_item_valid, out_change);
    end
  endtask

  task automatic test_vend();
    logic [1:0] codes [3] = '{2'd3, 2'd3, 2'd1};
    int         sums  [3] = '{25, 50, 55};
    step(START, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(START, 1, codes[i], 0, 0);
      vectors++;
      if (out_credit !== 8'(sums[i])) begin
        miscompares++;
        $display("FAIL vend_credit got %0d, required %0d", out_credit, sums[i]);
      end
    end
    step(SITEM, 0, 0, 2'd1, 0);
    vectors++;
    if (out_item !== 2'd1 || out_item_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL vend_select got item=%0d valid=%0b, required item=1 valid=1", out_item, out_item_valid);
    end
    exp_q.push_back('{K_DISP, 1});
    exp_q.push_back('{K_CHG, 35});
    step(SMONEY, 0, 0, 0, 0);
    step(SMONEY, 0, 0, 0, 0);
    step(SMONEY, 0, 0, 0, 0);
    vectors++;
    if (out_credit !== 8'd0 || out_item_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL vend_clear got credit=%0d valid=%0b, required credit=0 valid=0", out_credit, out_item_valid);
    end
  endtask

  task automatic test_err();
    step(START, 0, 0, 0, 0);
    step(START, 1, 2'd2, 0, 0);
    vectors++;
    if (out_credit !== 8'd10) begin
      miscompares++;
      $display("FAIL err_credit got %0d, required 10", out_credit);
    end
    step(SITEM, 0, 0, 2'd3, 0);
    exp_q.push_back('{K_ERR, 0});
    step(SMONEY, 0, 0, 0, 0);
    step(SMONEY, 0, 0, 0, 0);
    step(SMONEY, 0, 0, 0, 0);
    vectors++;
    if (out_credit !== 8'd10 || out_item_valid !== 1'b1 || out_item !== 2'd3) begin
      miscompares++;
      $display("FAIL err_retain got credit=%0d valid=%0b item=%0d, required credit=10 valid=1 item=3",
               out_credit, out_item_valid, out_item);
    end
    exp_q.push_back('{K_CHG, 10});
    step(CLEAR, 0, 0, 0, 0);
    step(CLEAR, 0, 0, 0, 0);
    step(CLEAR, 0, 0, 0, 0);
    vectors++;
    if (out_credit !== 8'd0 || out_item_valid !== 1'b0 || out_change !== 8'd10) begin
      miscompares++;
      $display("FAIL err_refund got credit=%0d valid=%0b change=%0d, required 0 0 10",
               out_credit, out_item_valid, out_change);
    end
  endtask

  task automatic test_exact();
    step(START, 0, 0, 0, 0);
    step(SITEM, 0, 0, 2'd3, 0);
    step(START, 1, 2'd2, 0, 0);
    step(SITEM, 0, 0, 2'd0, 0);
    vectors++;
    if (out_item !== 2'd0 || out_item_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL exact_overwrite got item=%0d valid=%0b, required item=0 valid=1", out_item, out_item_valid);
    end
    step(START, 1, 2'd1, 0, 0);
    vectors++;
    if (out_credit !== 8'd15) begin
      miscompares++;
      $display("FAIL exact_credit got %0d, required 15", out_credit);
    end
    exp_q.push_back('{K_DISP, 0});
    exp_q.push_back('{K_CHG, 0});
    step(SMONEY, 0, 0, 0, 0);
    step(SMONEY, 0, 0, 0, 0);
    step(SMONEY, 0, 0, 0, 0);
    vectors++;
    if (out_credit !== 8'd0 || out_change !== 8'd0) begin
      miscompares++;
      $display("FAIL exact_settle got credit=%0d change=%0d, required 0 0", out_credit, out_change);
    end
  endtask

  task automatic test_overflow();
    step(START, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(START, 1, 2'd3, 0, 0);
    vectors++;
    if (out_credit !== 8'd250) begin
      miscompares++;
      $display("FAIL overflow_fill got %0d, required 250", out_credit);
    end
    exp_q.push_back('{K_REJ, 0});
    step(START, 1, 2'd2, 0, 0);
    vectors++;
    if (out_credit !== 8'd250) begin
      miscompares++;
      $display("FAIL overflow_reject got %0d, required 250", out_credit);
    end
    step(START, 1, 2'd1, 0, 0);
    vectors++;
    if (out_credit !== 8'd255) begin
      miscompares++;
      $display("FAIL overflow_max got %0d, required 255", out_credit);
    end
    exp_q.push_back('{K_CHG, 255});
    step(CLEAR, 0, 0, 0, 0);
    step(CLEAR, 0, 0, 0, 0);
    step(CLEAR, 0, 0, 0, 0);
  endtask

  task automatic test_reject();
    step(START, 0, 0, 0, 0);
    step(START, 1, 2'd2, 0, 0);
    exp_q.push_back('{K_REJ, 0});
    step(SITEM, 1, 2'd3, 2'd2, 0);
    vectors++;
    if (out_credit !== 8'd10) begin
      miscompares++;
      $display("FAIL reject_sitem got %0d, required 10", out_credit);
    end
    exp_q.push_back('{K_REJ, 0});
    exp_q.push_back('{K_CHG, 10});
    step(CLEAR, 1, 2'd3, 0, 0);
    vectors++;
    if (out_credit !== 8'd10) begin
      miscompares++;
      $display("FAIL reject_clear got %0d, required 10", out_credit);
    end
    step(CLEAR, 0, 0, 0, 0);
    step(CLEAR, 0, 0, 0, 0);
    vectors++;
    if (out_credit !== 8'd0) begin
      miscompares++;
      $display("FAIL reject_refund got %0d, required 0", out_credit);
    end
  endtask

  task automatic test_restart();
    step(START, 0, 0, 0, 0);
    step(START, 1, 2'd3, 0, 0);
    step(START, 1, 2'd2, 0, 0);
    step(SITEM, 0, 0, 2'd2, 0);
    step(START, 1, 2'd1, 0, 0);
    vectors++;
    if (out_credit !== 8'd40 || out_item_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_setup got credit=%0d valid=%0b, required 40 1", out_credit, out_item_valid);
    end
    step(SMONEY, 1, 2'd3, 0, 1);
    vectors++;
    if (out_credit !== 8'd0 || out_item !== 2'd0 || out_item_valid !== 1'b0 || out_change !== 8'd0 ||
        {out_dispense, out_change_valid, out_err, out_coin_reject} !== 4'b0) begin
      miscompares++;
      $display("FAIL restart_clear got credit=%0d item=%0d valid=%0b change=%0d pulses=%b, required all zero",
               out_credit, out_item, out_item_valid, out_change,
               {out_dispense, out_change_valid, out_err, out_coin_reject});
    end
    step(CLEAR, 0, 0, 0, 0);
    step(CLEAR, 0, 0, 0, 0);
    vectors++;
    if (out_credit !== 8'd0 || out_change !== 8'd0) begin
      miscompares++;
      $display("FAIL restart_norefund got credit=%0d change=%0d, required 0 0", out_credit, out_change);
    end
  endtask

  initial begin
    in_restart = 1'b1; in_cmd = CLEAR; in_item = 2'd0; in_coin = 2'd0; in_coin_valid = 1'b0;
    test_reset();
    test_vend();
    test_err();
    test_exact();
    test_overflow();
    test_reject();
    test_restart();
    step(CLEAR, 0, 0, 0, 0);
    step(CLEAR, 0, 0, 0, 0);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending events, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/item_money_unit.md
ITEM_MONEY_UNIT -- requirements
Module: item_money_unit

Interface
REQ-001 Parameter PRICE0, default 8'd15: price of item 0 in coin units.
REQ-002 Parameter PRICE1, default 8'd20: price of item 1.
REQ-003 Parameter PRICE2, default 8'd25: price of item 2.
REQ-004 Parameter PRICE3, default 8'd50: price of item 3.
REQ-005 in_clka  input  1  the block's single clock; all state updates on its rising edge.
REQ-006 in_restart  input  1  synchronous, active-high reset.
REQ-007 in_cmd  input  2  command from the main FSM: 00 SITEM, 01 SMONEY, 10 CLEAR, 11 START.
REQ-008 in_item  input  2  item code, sampled on SITEM entry.
REQ-009 in_coin  input  2  coin value code: 00=1, 01=5, 10=10, 11=25 units.
REQ-010 in_coin_valid  input  1  one-cycle strobe qualifying in_coin.
REQ-011 out_credit  output  8  accumulated credit.
REQ-012 out_item  output  2  latched item selection.
REQ-013 out_item_valid  output  1  high while a selection is held.
REQ-014 out_dispense  output  1  one-cycle pulse: vend out_item.
REQ-015 out_change  output  8  change/refund amount, valid with out_change_valid.
REQ-016 out_change_valid  output  1  one-cycle pulse.
REQ-017 out_err  output  1  one-cycle pulse: settle refused (no selection or insufficient credit).
REQ-018 out_coin_reject  output  1  one-cycle pulse: coin refused.

Function
REQ-019 The block SHALL register in_cmd into prev_cmd each cycle; a "command entry" SHALL be a cycle where in_cmd != prev_cmd; all actions except coin accept occur only on command entry.
REQ-020 The block SHALL use states IDLE, COLLECT, SETTLE, REFUND; all outputs SHALL be registered, appearing one cycle after the triggering input.
REQ-021 IDLE -> COLLECT on START entry; COLLECT -> SETTLE on SMONEY entry; any state -> REFUND on CLEAR entry; SETTLE and REFUND SHALL return to IDLE after exactly one cycle.
REQ-022 SITEM entry in IDLE or COLLECT SHALL latch in_item into out_item and set out_item_valid; the state SHALL not change; a later SITEM entry SHALL overwrite the selection.
REQ-023 In COLLECT with in_cmd=START and in_coin_valid=1, credit SHALL increase by the decoded coin value if the 9-bit sum is <=255, else credit is unchanged and out_coin_reject pulses.
REQ-024 in_coin_valid=1 in any other state or command SHALL pulse out_coin_reject and leave credit unchanged.
REQ-025 In SETTLE: if out_item_valid=1 and credit >= PRICE[out_item], out_dispense pulses, out_change = credit - price with out_change_valid pulse (also when difference is 0), credit and out_item_valid clear.
REQ-026 In SETTLE otherwise: out_err pulses, credit and selection are retained.
REQ-027 In REFUND: if credit>0, out_change = credit with out_change_valid pulse; credit and out_item_valid clear; credit=0 produces no pulse.
REQ-028 CLEAR entry SHALL take priority over a coin strobe in the same cycle; the coin is rejected.
REQ-029 out_change SHALL hold its last value between pulses; pulse outputs SHALL be high for exactly one cycle.

Reset
REQ-030 While in_restart=1 on a clock edge: state=IDLE, prev_cmd=10 (CLEAR), out_credit=0, out_item=0, out_item_valid=0, out_change=0, all pulse outputs 0; no refund is issued for discarded credit.
REQ-031 Reset SHALL override every other input in the same cycle, including mid-COLLECT and mid-SETTLE.

Verification
REQ-032 Reset, START, coins 25,25,5 -> out_credit 25,50,55; SITEM item 1; SMONEY -> out_dispense, out_change=35, credit 0.
REQ-033 START, coin 10, SITEM item 3, SMONEY -> out_err pulse, credit stays 10, out_item_valid stays 1; CLEAR -> out_change=10 pulse.
REQ-034 Credit 250, coin 10 -> out_coin_reject, credit 250; coin 5 -> credit 255.
REQ-035 Coin strobe while in_cmd=SITEM, and coin strobe on CLEAR entry cycle -> out_coin_reject each, credit unchanged.
REQ-036 SMONEY with credit exactly PRICE0 and item 0 -> out_dispense, out_change=0 with out_change_valid.
REQ-037 Credit 40 in COLLECT, assert in_restart one cycle -> all outputs zero next cycle, no out_change_valid.
